// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming signed max-pool stage feeding a circular result buffer.
// Each run of POOL_N accepted samples is reduced to its signed maximum and queued
// in a DEPTH-entry buffer that drains through a first-word-fall-through stream.
// Optional feature macro: MAXPOOL_RELU_EN (seed each window with max(din, 0),
// fusing ReLU into the pooling so every result is non-negative).
module maxpool_stream #(
    parameter int DATA_W = 18,
    parameter int POOL_N = 4,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] din,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] dout,
    output logic [ADDR_W:0]          level,
    output logic                     win_done
);

    // win_cnt only needs to reach POOL_N-1; keep at least one bit for POOL_N == 1.
    localparam int CNT_W = (POOL_N > 1) ? $clog2(POOL_N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POOL_N - 1);
    localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]          win_cnt_q, win_cnt_d;
    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]           level_q, level_d;
    logic                      win_done_q, win_done_d;

    logic                      accept;
    logic                      pop;
    logic                      wr_en;
    logic signed [DATA_W-1:0]  wr_data;
    logic signed [DATA_W-1:0]  seed;
    logic signed [DATA_W-1:0]  cand;

    // Result storage; contents survive reset and clr, only pointers are cleared.
    logic signed [DATA_W-1:0]  mem [DEPTH];

    // Handshake terms: in_ready is derived from registered level only.
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = (level_q != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign dout      = mem[rd_ptr_q];
    assign level     = level_q;
    assign win_done  = win_done_q;

    // Window seed value and running signed maximum candidate (ties keep acc).
    always_comb begin
`ifdef MAXPOOL_RELU_EN
        seed = (din < 0) ? '0 : din;
`else
        seed = din;
`endif
        cand = (din > acc_q) ? din : acc_q;
    end

    // Window FSM, buffer pointers and level; clr overrides accept and pop.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        win_cnt_d  = win_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        wr_en      = 1'b0;
        wr_data    = cand;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (POOL_N == 1) begin
                        wr_en   = 1'b1;
                        wr_data = seed;
                    end else begin
                        acc_d     = seed;
                        win_cnt_d = CNT_W'(1);
                        state_d   = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (win_cnt_q == LAST_CNT) begin
                        wr_en     = 1'b1;
                        wr_data   = cand;
                        win_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        acc_d     = cand;
                        win_cnt_d = win_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        if (clr) begin
            state_d   = IDLE;
            acc_d     = '0;
            win_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            wr_en     = 1'b0;
        end

        win_done_d = wr_en;
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            win_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            win_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            win_cnt_q  <= win_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            win_done_q <= win_done_d;
        end
    end

    // Buffer write port; no reset so the array can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed testbench for maxpool_stream (POOL_N=4, DEPTH=4, DATA_W=18).
module tb_maxpool_stream;

    localparam int DATA_W = 18;
    localparam int POOL_N = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     clr;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] din;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] dout;
    logic [ADDR_W:0]          level;
    logic                     win_done;

    int vectors = 0;
    int errors  = 0;

    maxpool_stream #(
        .DATA_W(DATA_W),
        .POOL_N(POOL_N),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .level    (level),
        .win_done (win_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
        $display("vec %0d %s obs=%0d exp=%0d", vectors, tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        din      = DATA_W'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    int accepted;
    int pops;
    int exp_q[$];

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Reset state
        check("rst_level", level, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_win_done", win_done, 0);

        // 5, -3, 9, 2 back to back -> 9, one cycle latency
        in_valid = 1'b1;
        din = 5;  step();
        din = -3; step();
        din = 9;  step();
        din = 2;
        check("t1_ov_before", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("t1_ov_after", out_valid, 1);
        check("t1_win_done", win_done, 1);
        check("t1_dout", dout, 9);
        check("t1_level", level, 1);
        step();
        check("t1_win_done_once", win_done, 0);
        check("t1_dout_hold", dout, 9);
        pop_one();
        check("t1_level_pop", level, 0);

        // All-negative window
        push(-7); push(-2); push(-9); push(-4);
`ifdef MAXPOOL_RELU_EN
        check("t2_dout_neg", dout, 0);
`else
        check("t2_dout_neg", dout, -2);
`endif
        pop_one();

        // Gapped input 1..8 -> 4, 8
        for (int i = 1; i <= 8; i++) begin
            push(i);
            step();
        end
        check("t3_level", level, 2);
        check("t3_dout0", dout, 4);
        pop_one();
        check("t3_dout1", dout, 8);
        pop_one();
        check("t3_empty", out_valid, 0);

        // Fill to full with out_ready low, 20 samples offered
        accepted = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            din = DATA_W'(k);
            if (in_valid && in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        check("t4_accepted", accepted, 16);
        check("t4_level_full", level, 4);
        check("t4_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("t4_drain_valid", out_valid, 1);
            check("t4_drain_dout", dout, 4 * j + 3);
            step();
        end
        out_ready = 1'b0;
        check("t4_level_empty", level, 0);
        check("t4_in_ready_high", in_ready, 1);

        // 10 windows streamed with continuous out_ready
        exp_q.delete();
        for (int w = 0; w < 10; w++) exp_q.push_back(w * 10 + 5);
        pops = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 46; c++) begin
            if (c < 40) begin
                int offs[4] = '{1, 5, 3, 2};
                in_valid = 1'b1;
                din = DATA_W'((c / 4) * 10 + offs[c % 4]);
            end else begin
                in_valid = 1'b0;
            end
            check("t5_level_le1", (level <= 1) ? 1 : 0, 1);
            if (out_valid && out_ready) begin
                if (pops < 10) check("t5_dout", dout, exp_q[pops]);
                pops++;
            end
            step();
        end
        out_ready = 1'b0;
        check("t5_pops", pops, 10);
        check("t5_level_end", level, 0);

        // clr mid-window with 3 results buffered
        for (int i = 1; i <= 12; i++) push(i);
        check("t6_level3", level, 3);
        push(100); push(100);
        clr = 1'b1; in_valid = 1'b1; din = 100; out_ready = 1'b1;
        step();
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("t6_clr_level", level, 0);
        check("t6_clr_out_valid", out_valid, 0);
        check("t6_clr_win_done", win_done, 0);
        push(1); push(2);
        check("t6_no_early_close", out_valid, 0);
        push(3); push(4);
        check("t6_fresh_level", level, 1);
        check("t6_fresh_dout", dout, 4);
        pop_one();

        // Asynchronous reset mid-window with a result buffered
        push(7); push(1); push(2); push(3);
        push(50); push(60);
        check("t7_level_pre", level, 1);
        #3 rst_n = 1'b0;
        #1;
        check("t7_async_level", level, 0);
        check("t7_async_out_valid", out_valid, 0);
        check("t7_async_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        push(1); push(2); push(3);
        check("t7_no_early_close", out_valid, 0);
        push(4);
        check("t7_fresh_dout", dout, 4);
        check("t7_fresh_level", level, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Parametrised streaming max-pool stage with an output buffer. Consumes signed activations on a valid/ready stream, reduces each run of POOL_N consecutive samples to its signed maximum, and queues results in a DEPTH-entry circular buffer. The buffer drains through a second valid/ready stream to the next layer or to the UART transmit path. Supersedes the fixed 4:1, 18-bit, 128-entry pooling layer.

## Interface
- DATA_W, 18, sample and result width, two's complement
- POOL_N, 4, samples per pooling window, >= 1
- DEPTH, 128, result buffer entries, power of two, >= 2
- ADDR_W, $clog2(DEPTH), derived, do not override
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous frame clear (end of transmission)
- in_valid  in  1  din valid
- in_ready  out  1  block accepts din this cycle
- din  in  DATA_W  signed input sample
- out_valid  out  1  dout holds a queued result
- out_ready  in  1  consumer takes dout this cycle
- dout  out  DATA_W  signed result at buffer head
- level  out  ADDR_W+1  results currently buffered, 0..DEPTH
- win_done  out  1  one-cycle pulse: a window result was written

## Operation
- Input accept: in_valid && in_ready. Output pop: out_valid && out_ready.
- Window FSM, two states:
  - IDLE (no partial window). On accept: acc <= din, win_cnt <= 1 → ACCUM. If POOL_N == 1, write din directly and stay in IDLE.
  - ACCUM. On accept: cand = max(acc, din), signed compare. If win_cnt == POOL_N-1, write cand, win_cnt <= 0 → IDLE. Otherwise acc <= cand, win_cnt++.
- No accept: state, acc and win_cnt hold. Gaps in in_valid never split a window.
- Write: mem[wr_ptr] <= result, wr_ptr++ mod DEPTH, win_done = 1 the next cycle.
- Read: dout = mem[rd_ptr] (first-word fall-through). out_valid = (level != 0). On pop, rd_ptr++ mod DEPTH.
- level: +1 on write only, −1 on pop only, unchanged when both occur in the same cycle.
- in_ready = (level != DEPTH). Full stalls all input samples, not only window-closing ones. There is no full-buffer bypass, even if a pop occurs in the same cycle.
- dout is held stable while out_valid && !out_ready.
- Signed max ties keep the earlier value; the result is the same either way.
- Pointer wrap: DEPTH−1 → 0 for both pointers. level distinguishes full from empty.

## Timing
- Reset and clr values: state IDLE, win_cnt 0, acc 0, wr_ptr/rd_ptr 0, level 0, out_valid 0, win_done 0, in_ready 1. dout is don't-care while out_valid = 0. Memory contents are not cleared.
- clr has priority over accept and pop in the same cycle. Both are discarded, and any partial window is dropped.
- Reset assertion mid-window or mid-drain gives the same end state as clr, asynchronously.
- Latency: closing sample accepted in cycle t → out_valid = 1 and win_done = 1 in cycle t+1 (if the buffer was empty).
- Throughput: one sample per cycle in, one result per cycle out, sustained.
- in_ready depends only on registered level, with no combinational path from out_ready.

## Configuration
- MAXPOOL_RELU_EN defined: on entry to a window, acc is seeded with max(din, 0), and every written result is >= 0. This fuses ReLU with pooling and reproduces legacy zero-seeded behaviour.
- MAXPOOL_RELU_EN undefined: true signed maximum, so all-negative windows output their largest negative value.

## Test plan
- POOL_N=4, din 5, −3, 9, 2 back-to-back → one result 9. out_valid rises the cycle after the 4th accept. win_done pulses once.
- din −7, −2, −9, −4 → dout −2 without MAXPOOL_RELU_EN, 0 with it.
- in_valid toggled every other cycle over 8 samples 1..8 → results 4 and 8. Gaps do not split windows.
- DEPTH=4, out_ready=0, 20 samples offered → level reaches 4, in_ready = 0, 16 samples accepted. Release out_ready → 4 results pop in order, then in_ready = 1.
- Full wrap: push and pop 10 windows through DEPTH=4 with out_ready=1 continuously → results in order, level never exceeds 1, pointers wrap cleanly.
- clr asserted after 2 samples of a window while 3 results are buffered → level 0, out_valid 0 next cycle. The next 4 samples form a fresh window.
